// File: rtl/rng_pkg.sv
// Shared types and constants for the hemisphere direction sampler.
//   dir_comp_t   : signed Q1.11 direction/normal component
//   UNIT_SQ      : 1.0 squared in the Q2.22 domain of a sum of squares
//   MIN_SQ       : lower acceptance bound; rejects near-zero samples that
//                  would normalise badly downstream
//   FALLBACK_*   : direction emitted when every rejection attempt fails
//   state_t      : sampler FSM states
//   neg_sat      : two's complement negate with saturation of -2048
package rng_pkg;

    typedef logic signed [11:0] dir_comp_t;

    localparam logic [25:0] UNIT_SQ = 26'h040_0000;
    localparam logic [25:0] MIN_SQ  = 26'h000_4000;

    localparam dir_comp_t FALLBACK_X = 12'sd0;
    localparam dir_comp_t FALLBACK_Y = 12'sd0;
    localparam dir_comp_t FALLBACK_Z = 12'sd2047;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRAW_X = 3'd1,
        DRAW_Y = 3'd2,
        DRAW_Z = 3'd3,
        TEST   = 3'd4,
        OUT    = 3'd5
    } state_t;

    // -2048 has no positive counterpart in Q1.11, so it maps to +2047.
    function automatic dir_comp_t neg_sat(input dir_comp_t v);
        dir_comp_t r;
        if (v == 12'sh800) begin
            r = 12'sd2047;
        end else begin
            r = -v;
        end
        return r;
    endfunction

endpackage

// File: rtl/dir_sq_sum.sv
// Combinational sum of three signed 12x12 products.
//   a_x/a_y/a_z : first operand vector (signed Q1.11)
//   b_x/b_y/b_z : second operand vector (signed Q1.11)
//   sum         : a_x*b_x + a_y*b_y + a_z*b_z, signed 26 bits
// Tie b to a for a sum of squares (always non-negative, so the result can be
// read as unsigned), or feed two different vectors for a dot product.
module dir_sq_sum
    import rng_pkg::*;
(
    input  dir_comp_t          a_x,
    input  dir_comp_t          a_y,
    input  dir_comp_t          a_z,
    input  dir_comp_t          b_x,
    input  dir_comp_t          b_y,
    input  dir_comp_t          b_z,
    output logic signed [25:0] sum
);

    // -2048 * -2048 = 2^22 still fits a signed 24-bit product.
    logic signed [23:0] p_x;
    logic signed [23:0] p_y;
    logic signed [23:0] p_z;

    assign p_x = a_x * b_x;
    assign p_y = a_y * b_y;
    assign p_z = a_z * b_z;

    assign sum = 26'(p_x) + 26'(p_y) + 26'(p_z);

endmodule

// File: rtl/hemi_dir_sampler.sv
// Rejection-sampling unit-ball direction generator for diffuse bounce rays.
// Draws three consecutive PRNG words as a candidate vector and accepts it when
// its squared length lies in [MIN_SQ, UNIT_SQ). After MAX_TRIES rejections
// the fixed fallback direction (0,0,2047) is emitted instead.
//
// Optional build macro HEMI_FLIP_EN: the surface normal is captured on request
// accept and an accepted sample pointing away from it is negated, so that the
// direction lies in the normal's hemisphere. The fallback is never flipped.
// Without the macro the normal inputs are ignored.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   rand_num[11:0]             PRNG word, new value every cycle
//   req_valid / req_ready      request handshake (ready only in IDLE)
//   norm_x/y/z[11:0]           signed Q1.11 surface normal
//   dir_valid / dir_ready      direction handshake (valid only in OUT)
//   dir_x/y/z[11:0]            signed Q1.11 direction, held during OUT
//   dir_fallback               direction is the fallback
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | waiting for a request, req_ready high
// DRAW_X | register rand_num as x component
// DRAW_Y | register rand_num as y component
// DRAW_Z | register rand_num as z component
// TEST   | range check of x^2+y^2+z^2, load output or retry
// OUT    | direction presented, waiting for dir_ready
module hemi_dir_sampler
    import rng_pkg::*;
#(
    parameter int MAX_TRIES = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic        [11:0] rand_num,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic signed [11:0] norm_x,
    input  logic signed [11:0] norm_y,
    input  logic signed [11:0] norm_z,
    output logic               dir_valid,
    input  logic               dir_ready,
    output logic signed [11:0] dir_x,
    output logic signed [11:0] dir_y,
    output logic signed [11:0] dir_z,
    output logic               dir_fallback
);

    localparam logic [7:0] LAST_TRY = 8'(MAX_TRIES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] tries;

    dir_comp_t  smp_x;
    dir_comp_t  smp_y;
    dir_comp_t  smp_z;

    logic signed [25:0] sq_sum;
    logic        [25:0] sq_sum_u;
    logic               in_range;
    logic               retry;
    logic               flip;
    logic               take_req;

    dir_sq_sum u_sq (
        .a_x (smp_x),
        .a_y (smp_y),
        .a_z (smp_z),
        .b_x (smp_x),
        .b_y (smp_y),
        .b_z (smp_z),
        .sum (sq_sum)
    );

    // A sum of squares is never negative, so the bit pattern is the magnitude.
    assign sq_sum_u = sq_sum;
    assign in_range = (sq_sum_u >= MIN_SQ) && (sq_sum_u < UNIT_SQ);
    assign retry    = (tries < LAST_TRY);
    assign take_req = req_valid && (state == IDLE);

`ifdef HEMI_FLIP_EN
    dir_comp_t          nrm_x;
    dir_comp_t          nrm_y;
    dir_comp_t          nrm_z;
    logic signed [25:0] dot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nrm_x <= '0;
            nrm_y <= '0;
            nrm_z <= '0;
        end else if (take_req) begin
            nrm_x <= norm_x;
            nrm_y <= norm_y;
            nrm_z <= norm_z;
        end
    end

    dir_sq_sum u_dot (
        .a_x (smp_x),
        .a_y (smp_y),
        .a_z (smp_z),
        .b_x (nrm_x),
        .b_y (nrm_y),
        .b_z (nrm_z),
        .sum (dot)
    );

    assign flip = dot[25];
`else
    // Normal inputs are deliberately unused in this build.
    logic unused_norm;
    assign unused_norm = ^{norm_x, norm_y, norm_z};
    assign flip        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        dir_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = DRAW_X;
                end
            end
            DRAW_X: state_nxt = DRAW_Y;
            DRAW_Y: state_nxt = DRAW_Z;
            DRAW_Z: state_nxt = TEST;
            TEST: begin
                if (in_range || !retry) begin
                    state_nxt = OUT;
                end else begin
                    state_nxt = DRAW_X;
                end
            end
            OUT: begin
                dir_valid = 1'b1;
                if (dir_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tries        <= '0;
            smp_x        <= '0;
            smp_y        <= '0;
            smp_z        <= '0;
            dir_x        <= '0;
            dir_y        <= '0;
            dir_z        <= '0;
            dir_fallback <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_req) begin
                        tries <= '0;
                    end
                end
                DRAW_X: smp_x <= rand_num;
                DRAW_Y: smp_y <= rand_num;
                DRAW_Z: smp_z <= rand_num;
                TEST: begin
                    if (in_range) begin
                        dir_x        <= flip ? neg_sat(smp_x) : smp_x;
                        dir_y        <= flip ? neg_sat(smp_y) : smp_y;
                        dir_z        <= flip ? neg_sat(smp_z) : smp_z;
                        dir_fallback <= 1'b0;
                    end else if (retry) begin
                        tries <= tries + 8'd1;
                    end else begin
                        dir_x        <= FALLBACK_X;
                        dir_y        <= FALLBACK_Y;
                        dir_z        <= FALLBACK_Z;
                        dir_fallback <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
